// File: rtl/sysu_vga_timing_detect.sv
// Receive-side VGA timing detector: measures incoming hsync/vsync geometry, locks after
// consecutive identical frames and regenerates active-window pixel coordinates.
module sysu_vga_timing_detect #(
  parameter int HD          = 1440,
  parameter int VD          = 900,
  parameter int HT_EXP      = 1904,
  parameter int VT_EXP      = 932,
  parameter int HA_EXP      = 152,
  parameter int VA_EXP      = 3,
  parameter int H_OFS       = 384,
  parameter int V_OFS       = 30,
  parameter int LOCK_FRAMES = 2
) (
  input  logic        vga_pclk,
  input  logic        vga_rst,
  input  logic        hsync_in,
  input  logic        vsync_in,
  output logic        locked,
  output logic        mode_ok,
  output logic        lock_err,
  output logic [11:0] h_total,
  output logic [11:0] h_sync_w,
  output logic [10:0] v_total,
  output logic [10:0] v_sync_w,
  output logic        rec_valid,
  output logic [11:0] rec_h_cnt,
  output logic [10:0] rec_v_cnt
);

  typedef enum logic {UNLOCK, LOCKED} state_t;

  // line_cnt is vp+1 (0 means no hsync fall yet this frame), so vp bounds shift by one
  localparam logic [11:0] H_LO   = 12'(H_OFS);
  localparam logic [11:0] H_HI   = 12'(H_OFS + HD);
  localparam logic [10:0] V_LO   = 11'(V_OFS + 1);
  localparam logic [10:0] V_HI   = 11'(V_OFS + VD + 1);
  localparam logic [11:0] TMO    = 12'(2 * HT_EXP - 1);
  localparam logic [11:0] HT_C   = 12'(HT_EXP);
  localparam logic [10:0] VT_C   = 11'(VT_EXP);
  localparam logic [11:0] HA_C   = 12'(HA_EXP);
  localparam logic [10:0] VA_C   = 11'(VA_EXP);
  localparam logic [7:0]  LOCK_C = 8'(LOCK_FRAMES);

  function automatic logic [11:0] sat_inc12(input logic [11:0] v);
    return (v == 12'hFFF) ? v : v + 12'd1;
  endfunction

  function automatic logic [10:0] sat_inc11(input logic [10:0] v);
    return (v == 11'h7FF) ? v : v + 11'd1;
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  state_t      state;
  logic        hs_p0, hs_p1, hs_p2, vs_p0, vs_p1, vs_p2;
  logic        h_fall, h_rise, v_fall, h_seen;
  logic [11:0] hp, prev_h, lk_h;
  logic [10:0] line_cnt, vlow_cnt, prev_v, lk_v;
  logic [7:0]  stable;

  logic [11:0] h_period, h_tot_n, hsw_n;
  logic [10:0] v_tot_n, vsw_n;
  logic [7:0]  stable_n;
  logic        h_cap, frame_ok, frame_eq, lose, lock_n, in_win;

  assign h_fall = hs_p2 & ~hs_p1;
  assign h_rise = ~hs_p2 & hs_p1;
  assign v_fall = vs_p2 & ~vs_p1;

  always_comb begin
    h_period = sat_inc12(hp);
    h_cap    = h_fall & h_seen;
    h_tot_n  = h_cap ? h_period : h_total;
    hsw_n    = h_rise ? h_period : h_sync_w;
    v_tot_n  = v_fall ? line_cnt : v_total;
    vsw_n    = v_fall ? vlow_cnt : v_sync_w;
    frame_ok = (h_tot_n != 12'd0) && (line_cnt != 11'd0);
    frame_eq = (h_tot_n == prev_h) && (line_cnt == prev_v);
    // stable counts consecutive identical, fully measured frames
    stable_n = !frame_ok ? 8'd0 : (frame_eq ? sat_inc8(stable) : 8'd1);
    lose     = (h_cap && (h_period != lk_h)) ||
               (v_fall && (line_cnt != lk_v)) ||
               (!h_fall && (hp >= TMO));
    lock_n   = (state == LOCKED) ? !lose : (v_fall && (stable_n >= LOCK_C));
    in_win   = lock_n && (hp >= H_LO) && (hp < H_HI) &&
               (line_cnt >= V_LO) && (line_cnt < V_HI);
  end

  always_ff @(posedge vga_pclk or posedge vga_rst) begin
    if (vga_rst) begin
      {hs_p0, hs_p1, hs_p2} <= 3'b111;
      {vs_p0, vs_p1, vs_p2} <= 3'b111;
      state     <= UNLOCK;
      h_seen    <= 1'b0;
      hp        <= '0;
      line_cnt  <= '0;
      vlow_cnt  <= '0;
      prev_h    <= '0;
      prev_v    <= '0;
      lk_h      <= '0;
      lk_v      <= '0;
      stable    <= '0;
      h_total   <= '0;
      h_sync_w  <= '0;
      v_total   <= '0;
      v_sync_w  <= '0;
      locked    <= 1'b0;
      mode_ok   <= 1'b0;
      lock_err  <= 1'b0;
      rec_valid <= 1'b0;
      rec_h_cnt <= '0;
      rec_v_cnt <= '0;
    end else begin
      // stage p0/p1: synchroniser, p2: edge reference
      hs_p0 <= hsync_in;
      hs_p1 <= hs_p0;
      hs_p2 <= hs_p1;
      vs_p0 <= vsync_in;
      vs_p1 <= vs_p0;
      vs_p2 <= vs_p1;

      hp     <= h_fall ? 12'd0 : h_period;
      h_seen <= h_seen | h_fall;
      if (v_fall) begin
        line_cnt <= {10'd0, h_fall};
        vlow_cnt <= {10'd0, h_fall};
        prev_h   <= h_tot_n;
        prev_v   <= line_cnt;
      end else if (h_fall) begin
        line_cnt <= sat_inc11(line_cnt);
        if (!vs_p1) vlow_cnt <= sat_inc11(vlow_cnt);
      end

      h_total  <= h_tot_n;
      h_sync_w <= hsw_n;
      v_total  <= v_tot_n;
      v_sync_w <= vsw_n;

      lock_err <= 1'b0;
      case (state)
        UNLOCK: if (v_fall) begin
          stable <= stable_n;
          if (lock_n) begin
            state <= LOCKED;
            lk_h  <= h_tot_n;
            lk_v  <= line_cnt;
          end
        end
        LOCKED: if (lose) begin
          state    <= UNLOCK;
          stable   <= '0;
          lock_err <= 1'b1;
        end
      endcase

      // outputs registered from next-state lock so they drop with lock_err
      locked    <= lock_n;
      mode_ok   <= lock_n && (h_tot_n == HT_C) && (v_tot_n == VT_C) &&
                   (hsw_n == HA_C) && (vsw_n == VA_C);
      rec_valid <= in_win;
      rec_h_cnt <= in_win ? hp - H_LO : 12'd0;
      rec_v_cnt <= in_win ? line_cnt - V_LO : 11'd0;
    end
  end

endmodule
